alu_exec_unit: RTL and testbench

Parametrised successor to the single-cycle ALU/register-file top of the RV32 core. It bundles the register file, the ALUsrc operand mux and the ALU. It adds a valid/ready issue handshake, registered results, and an iterative multi-cycle multiply/divide path for the RV32M subset. It sits in the execute/writeback slot between the decoder/control unit and the PC/branch logic (EQ).

---
 rtl/alu_exec_unit.sv | 180 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute/writeback unit: register file, operand2 mux, single-cycle ALU and
// an iterative radix-2 multiply/divide engine behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int A_WIDTH  = 5,
  parameter int D_WIDTH  = 32,
  parameter int A0_INDEX = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ALUsrc,
  input  logic [3:0]         ALUctrl,
  input  logic               RegWrite,
  input  logic [A_WIDTH-1:0] rs1,
  input  logic [A_WIDTH-1:0] rs2,
  input  logic [A_WIDTH-1:0] rd,
  input  logic [D_WIDTH-1:0] ImmOp,
  output logic               done,
  output logic [D_WIDTH-1:0] result,
  output logic               EQ,
  output logic [D_WIDTH-1:0] a0
);

  localparam int NREG  = 2 ** A_WIDTH;
  localparam int SH_W  = $clog2(D_WIDTH);
  localparam int CNT_W = $clog2(D_WIDTH) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [D_WIDTH-1:0] regs [NREG];

  // Multi-cycle context latched at acceptance
  logic [3:0]         op_p1;
  logic [D_WIDTH-1:0] b_p1;
  logic [D_WIDTH-1:0] hi_p1;
  logic [D_WIDTH-1:0] lo_p1;
  logic [A_WIDTH-1:0] rd_p1;
  logic               wr_p1;
  logic               eq_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic [D_WIDTH-1:0] op1, op2;
  logic               is_multi, accept, last_step;
  logic               fin_single, fin_multi;
  logic [D_WIDTH:0]   mul_sum, div_shift;
  logic               div_ok;
  logic [D_WIDTH-1:0] step_hi, step_lo;
  logic [D_WIDTH-1:0] fin_result;
  logic               fin_eq;
  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;

  // Single-cycle operations; reserved codes yield zero.
  function automatic logic [D_WIDTH-1:0] alu_single(input logic [3:0] ctrl,
                                                    input logic [D_WIDTH-1:0] a,
                                                    input logic [D_WIDTH-1:0] b);
    logic signed [D_WIDTH-1:0] sa;
    logic signed [D_WIDTH-1:0] sb;
    logic [SH_W-1:0]           sh;
    logic [D_WIDTH-1:0]        r;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (ctrl)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = {{(D_WIDTH-1){1'b0}}, (sa < sb)};
      4'b0110: r = {{(D_WIDTH-1){1'b0}}, (a < b)};
      4'b0111: r = a << sh;
      4'b1000: r = a >> sh;
      4'b1001: r = D_WIDTH'(sa >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op1       = regs[rs1];
  assign op2       = ALUsrc ? ImmOp : regs[rs2];
  assign is_multi  = (ALUctrl >= 4'd10) && (ALUctrl <= 4'd13);
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_p1 == CNT_W'(D_WIDTH - 1));
  assign a0        = regs[A_WIDTH'(A0_INDEX)];

  // One radix-2 iteration: shift-add multiply or restoring divide.
  // {hi,lo} holds product/multiplier or remainder/quotient.
  always_comb begin
    mul_sum   = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, b_p1} : '0);
    div_shift = {hi_p1, lo_p1[D_WIDTH-1]};
    div_ok    = (div_shift >= {1'b0, b_p1});
    if (op_p1[2]) begin
      step_hi = div_ok ? D_WIDTH'(div_shift - {1'b0, b_p1}) : div_shift[D_WIDTH-1:0];
      step_lo = {lo_p1[D_WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[D_WIDTH:1];
      step_lo = {mul_sum[0], lo_p1[D_WIDTH-1:1]};
    end
  end

  // Completion selection: single-cycle op at acceptance or final iteration.
  always_comb begin
    fin_single = accept && !is_multi;
    fin_multi  = (state == BUSY) && last_step;
    fin_result = '0;
    fin_eq     = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = rd;
    if (fin_multi) begin
      fin_result = op_p1[0] ? step_hi : step_lo;
      fin_eq     = eq_p1;
      wr_en      = wr_p1;
      wr_addr    = rd_p1;
    end else if (fin_single) begin
      fin_result = alu_single(ALUctrl, op1, op2);
      fin_eq     = (op1 == op2);
      wr_en      = RegWrite;
    end
  end

  // Register file write port; register 0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= fin_result;
    end
  end

  // Issue/iterate state machine with registered result, EQ and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= '0;
      EQ     <= 1'b0;
      op_p1  <= '0;
      b_p1   <= '0;
      hi_p1  <= '0;
      lo_p1  <= '0;
      rd_p1  <= '0;
      wr_p1  <= 1'b0;
      eq_p1  <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      done <= fin_single || fin_multi;
      if (fin_single || fin_multi) begin
        result <= fin_result;
        EQ     <= fin_eq;
      end
      case (state)
        IDLE: begin
          if (accept && is_multi) begin
            op_p1  <= ALUctrl;
            b_p1   <= op2;
            hi_p1  <= '0;
            lo_p1  <= op1;
            rd_p1  <= rd;
            wr_p1  <= RegWrite;
            eq_p1  <= (op1 == op2);
            cnt_p1 <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          hi_p1  <= step_hi;
          lo_p1  <= step_lo;
          cnt_p1 <= cnt_p1 + 1'b1;
          if (last_step) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expectations are queued at issue and
// compared against each done pulse.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        ALUsrc;
  logic [3:0]  ALUctrl;
  logic        RegWrite;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] ImmOp;
  logic        done;
  logic [31:0] result;
  logic        EQ;
  logic [31:0] a0;

  alu_exec_unit #(.A_WIDTH(5), .D_WIDTH(32), .A0_INDEX(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .RegWrite(RegWrite),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp),
    .done(done), .result(result), .EQ(EQ), .a0(a0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        eq;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $unsigned($signed(a) >>> b[4:0]);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Compare every completion against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("eq", EQ, e.eq);
        check("latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  task automatic issue(input logic [3:0] c, input logic src, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic [31:0] imm,
                       input logic we, input logic track);
    int n;
    exp_t e;
    logic [31:0] a, b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check("issue_timeout", 1, 0);
      return;
    end
    ALUctrl = c; ALUsrc = src; rs1 = s1; rs2 = s2; rd = d; ImmOp = imm;
    RegWrite = we; in_valid = 1'b1;
    a = mregs[s1];
    b = src ? imm : mregs[s2];
    e.res = model(c, a, b);
    e.eq  = (a == b);
    e.lat = (c >= 4'd10 && c <= 4'd13) ? 33 : 1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (track) begin
      sb.push_back(e);
      if (we && d != 0) mregs[d] = e.res;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int busy;
    rst_n = 1'b0; in_valid = 0; ALUsrc = 0; ALUctrl = 0; RegWrite = 0;
    rs1 = 0; rs2 = 0; rd = 0; ImmOp = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a0", a0, 0);
    check("rst_result", result, 0);
    check("rst_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_eq", EQ, 0);

    // 1: ADDI x10 = 5
    issue(4'd0, 1, 0, 0, 10, 32'd5, 1, 1);
    drain();
    check("a0_after_addi", a0, 32'd5);

    // 2: back-to-back dependent ops
    issue(4'd0, 1, 0, 0, 1, 32'd7, 1, 1);
    issue(4'd1, 0, 1, 1, 3, 32'd0, 1, 1);
    drain();

    // 3: MUL / MULHU
    issue(4'd0, 1, 0, 0, 1, 32'hFFFF_FFFF, 1, 1);
    issue(4'd0, 1, 0, 0, 2, 32'd2, 1, 1);
    issue(4'd10, 0, 1, 2, 3, 32'd0, 1, 1);
    busy = 0;
    while (!in_ready && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check("busy_cycles", busy, 32);
    issue(4'd11, 0, 1, 2, 4, 32'd0, 1, 1);
    drain();

    // 4: DIVU / REMU including divide by zero
    issue(4'd0, 1, 0, 0, 4, 32'd100, 1, 1);
    issue(4'd0, 1, 0, 0, 5, 32'd7, 1, 1);
    issue(4'd0, 1, 0, 0, 7, 32'd9, 1, 1);
    issue(4'd12, 0, 4, 5, 8, 32'd0, 1, 1);
    issue(4'd13, 0, 4, 5, 9, 32'd0, 1, 1);
    issue(4'd12, 0, 7, 0, 11, 32'd0, 1, 1);
    issue(4'd13, 0, 7, 0, 12, 32'd0, 1, 1);
    drain();

    // 5: writes to x0 are discarded
    issue(4'd0, 1, 0, 0, 0, 32'h1234, 1, 1);
    issue(4'd0, 0, 0, 0, 13, 32'd0, 1, 1);
    drain();

    // Mixed operations with random operands, including reserved codes
    for (int i = 1; i < 7; i++) issue(4'd0, 1, 0, 0, 5'(i), $urandom, 1, 1);
    issue(4'd0, 1, 0, 0, 6, 32'h8000_0010, 1, 1);
    for (int i = 0; i < 24; i++)
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 6)),
            5'($urandom_range(0, 6)), 5'($urandom_range(14, 20)), $urandom, 1, 1);
    drain();

    // 6: reset in the middle of a MUL targeting x10
    issue(4'd10, 0, 1, 2, 10, 32'd0, 1, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_done", done, 0);
    check("midrst_ready", in_ready, 1);
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_a0", a0, 0);
    check("post_rst_ready", in_ready, 1);
    check("post_rst_result", result, 0);
    issue(4'd0, 1, 0, 0, 10, 32'd3, 1, 1);
    drain();
    check("post_rst_add_a0", a0, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
